// File: rtl/chop_demod_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | chop_demod_if : sample/config input bus and period-result outputs  |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
interface chop_demod_if #(
    parameter int DATA_W = 18,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16
);
    logic              demod_en;
    logic              chop_default;
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic              chop_i;
    logic              hold_i;
    logic [ACC_W-1:0]  demod_data_o;
    logic [ACC_W-1:0]  offset_o;
    logic [CNT_W-1:0]  sample_cnt_o;
    logic              demod_valid_o;
    logic              overflow_o;

    modport master (
        output demod_en, chop_default, adc_data, adc_valid, chop_i, hold_i,
        input  demod_data_o, offset_o, sample_cnt_o, demod_valid_o, overflow_o
    );

    modport slave (
        input  demod_en, chop_default, adc_data, adc_valid, chop_i, hold_i,
        output demod_data_o, offset_o, sample_cnt_o, demod_valid_o, overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/chop_demod.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | chop_demod : per-period chopper demodulator with saturating sums   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module chop_demod #(
    parameter int DATA_W = 18,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         reset,
    chop_demod_if.slave  bus
);
    localparam int SW = ACC_W + 2;
    localparam logic signed [SW-1:0] C_MAX = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [SW-1:0] C_MIN = {3'b111, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_ACCUM = 2'd2
    } state_t;

    state_t                    state_q;
    logic                      prev_vld_q, prev_phase_q;
    logic signed [ACC_W-1:0]   dacc_q, oacc_q, dacc_d, oacc_d;
    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;
    logic signed [ACC_W-1:0]   demod_q, offset_q;
    logic        [CNT_W-1:0]   cnt_out_q;
    logic                      valid_q, ovf_out_q;

    logic                      boundary, take;
    logic signed [SW-1:0]      x_ext, term, sum_d, sum_o;
    logic signed [ACC_W-1:0]   base_d, base_o;
    logic        [CNT_W-1:0]   base_c;
    logic                      base_f;
    logic        [ACC_W:0]     sat_d, sat_o;

    // Returns {clamped, value}
    function automatic logic [ACC_W:0] sat(input logic signed [SW-1:0] v);
        if (v > C_MAX)      sat = {1'b1, C_MAX[ACC_W-1:0]};
        else if (v < C_MIN) sat = {1'b1, C_MIN[ACC_W-1:0]};
        else                sat = {1'b0, v[ACC_W-1:0]};
    endfunction

    always_comb begin
        boundary = bus.adc_valid && prev_vld_q && (prev_phase_q != bus.chop_default)
                   && (bus.chop_i == bus.chop_default);
        take     = bus.adc_valid && !bus.hold_i;
        x_ext    = {{(SW-DATA_W){bus.adc_data[DATA_W-1]}}, bus.adc_data};
        term     = (bus.chop_i == bus.chop_default) ? x_ext : -x_ext;
        // A boundary sample opens a fresh period, so it builds on zero.
        base_d   = boundary ? '0 : dacc_q;
        base_o   = boundary ? '0 : oacc_q;
        base_c   = boundary ? '0 : cnt_q;
        base_f   = boundary ? 1'b0 : ovf_q;
        sum_d    = {{2{base_d[ACC_W-1]}}, base_d} + term;
        sum_o    = {{2{base_o[ACC_W-1]}}, base_o} + x_ext;
        sat_d    = sat(sum_d);
        sat_o    = sat(sum_o);
        dacc_d   = base_d;
        oacc_d   = base_o;
        cnt_d    = base_c;
        ovf_d    = base_f;
        if (take) begin
            dacc_d = sat_d[ACC_W-1:0];
            oacc_d = sat_o[ACC_W-1:0];
            cnt_d  = (&base_c) ? base_c : base_c + CNT_W'(1);
            ovf_d  = base_f | sat_d[ACC_W] | sat_o[ACC_W] | (&base_c);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            prev_vld_q   <= 1'b0;
            prev_phase_q <= 1'b0;
            dacc_q       <= '0;
            oacc_q       <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            demod_q      <= '0;
            offset_q     <= '0;
            cnt_out_q    <= '0;
            ovf_out_q    <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!bus.demod_en || state_q == ST_IDLE) begin
                state_q      <= bus.demod_en ? ST_SYNC : ST_IDLE;
                prev_vld_q   <= 1'b0;
                prev_phase_q <= 1'b0;
                dacc_q       <= '0;
                oacc_q       <= '0;
                cnt_q        <= '0;
                ovf_q        <= 1'b0;
            end else if (bus.adc_valid) begin
                prev_vld_q   <= 1'b1;
                prev_phase_q <= bus.chop_i;
                case (state_q)
                    ST_SYNC: begin
                        if (boundary) begin
                            state_q <= ST_ACCUM;
                            dacc_q  <= dacc_d;
                            oacc_q  <= oacc_d;
                            cnt_q   <= cnt_d;
                            ovf_q   <= ovf_d;
                        end
                    end
                    ST_ACCUM: begin
                        if (boundary) begin
                            demod_q   <= dacc_q;
                            offset_q  <= oacc_q;
                            cnt_out_q <= cnt_q;
                            ovf_out_q <= ovf_q;
                            valid_q   <= 1'b1;
                        end
                        dacc_q <= dacc_d;
                        oacc_q <= oacc_d;
                        cnt_q  <= cnt_d;
                        ovf_q  <= ovf_d;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.demod_data_o  = demod_q;
    assign bus.offset_o      = offset_q;
    assign bus.sample_cnt_o  = cnt_out_q;
    assign bus.demod_valid_o = valid_q;
    assign bus.overflow_o    = ovf_out_q;
endmodule
`default_nettype wire

// File: doc/chop_demod.md
# chop_demod

Synchronous chopper demodulator for the interlock front-panel acquisition path. It is the receiving end of the chopper generator. It takes ADC samples together with the pipeline-aligned chop phase and data-hold flags, and discards samples taken during settle/hold. It sign-corrects the remaining samples by chop phase and accumulates them over one full chop period. Once per period it emits the demodulated sum, the residual offset sum and the sample count to downstream interlock comparators.

## Interface
- `DATA_W`, 18: ADC sample width, two's complement.
- `ACC_W`, 32: accumulator and output width, signed.
- `CNT_W`, 16: sample counter width.
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `demod_en` input 1: enable; low forces IDLE.
- `chop_default` input 1: chop level of the positive (default) phase.
- `adc_data` input DATA_W: signed sample.
- `adc_valid` input 1: `adc_data`, `chop_i` and `hold_i` are qualified this cycle.
- `chop_i` input 1: chop phase aligned to `adc_data` (delayed chop).
- `hold_i` input 1: sample is inside a hold/settle window; discard it.
- `demod_data_o` output ACC_W: Σ(sign·x) for the last completed period.
- `offset_o` output ACC_W: Σx for the last completed period.
- `sample_cnt_o` output CNT_W: number of accumulated samples in the last period.
- `demod_valid_o` output 1: one-cycle strobe when the outputs above update.
- `overflow_o` output 1: saturation occurred in the reported period.

## Operation
- State machine with three states:
  - IDLE:
    - Entered on `reset` or `demod_en`=0.
    - Accumulators, counter, phase history and overflow flag are cleared.
    - No strobes.
    - `demod_en`=1 → SYNC.
  - SYNC:
    - Samples are discarded.
    - The block tracks `prev_phase` (chop_i of the last valid sample).
    - A boundary → ACCUM, and the boundary sample is accumulated as the first sample of the period.
  - ACCUM:
    - Each valid sample is accumulated.
    - On a boundary, the period result is published, then accumulation restarts with the boundary sample.
- Boundary: `adc_valid`=1, `chop_i`==`chop_default`, and `prev_phase`!=`chop_default`. Phase history updates only on `adc_valid` and is updated for held samples as well.
- Accumulate rule, applied only when `adc_valid`=1 and `hold_i`=0:
  - sign = +1 if `chop_i`==`chop_default`, else −1.
  - acc_d += sign·x.
  - acc_o += x.
  - cnt += 1.
- Held samples update only the phase history.
- Arithmetic:
  - x is sign-extended to ACC_W. Negation is computed in ACC_W+1 bits before saturation, so −(−2^(DATA_W−1)) is exact.
  - Both accumulators saturate at ±(2^(ACC_W−1)−1 / −2^(ACC_W−1)). Any saturation sets the period overflow flag.
  - cnt saturates at 2^CNT_W−1 and also sets the overflow flag.
- Publish:
  - `demod_data_o`, `offset_o` and `sample_cnt_o` take the pre-boundary accumulator values, i.e. excluding the boundary sample.
  - `overflow_o` takes the period flag.
  - The period flag is then cleared.
- Outputs hold their value between strobes.
- A period with zero accumulated samples (all held) still publishes, with cnt=0 and sums=0.

## Timing
- Reset values: all outputs 0, state IDLE.
- Latency: `demod_valid_o` and the updated outputs appear on the clk edge after the boundary sample's `adc_valid` cycle (1-cycle latency).
- `demod_valid_o` is high for exactly 1 cycle per boundary and is never asserted from IDLE or SYNC.
- Back-to-back valid samples every cycle are supported; no backpressure.
- Boundary and hold on the same sample: the publish occurs, the new period starts with acc=0 and cnt=0, and the sample is not accumulated.
- `demod_en` falling mid-period: IDLE on the next edge. The partial period is dropped and the outputs retain the last published values.
- `reset` mid-operation: the next edge gives all outputs 0 and IDLE, overriding `demod_en`.
- `chop_default` is static while `demod_en`=1. A change requires a pass through IDLE.

## Test plan
- Chopped DC, period 16, half 8, hold on the first 3 samples of each half, x=+50 in default phase and −50 in the other phase, after sync → every strobe gives `demod_data_o`=500, `offset_o`=0, `sample_cnt_o`=10, `overflow_o`=0.
- Pure offset, same timing, x=+100 constant → `demod_data_o`=0, `offset_o`=1000, `sample_cnt_o`=10.
- Enable in mid-phase, first sample non-default → no strobe until the first default-phase re-entry. The first strobe occurs exactly one full period later.
- Saturation, ACC_W=20, x=+131071 (max), unheld, period 32 → `demod_data_o` clamps correctly (both halves cancel partially); `offset_o`=524287, `overflow_o`=1. The next period with small data has `overflow_o`=0.
- `adc_valid` gaps (valid every 3rd cycle) with the same data as test 1 → identical results; strobe 1 cycle after the boundary's valid cycle.
- `reset` asserted 5 samples into ACCUM → next cycle all outputs 0. After release, no strobe until a new SYNC boundary. Repeat using `demod_en`=0 instead → outputs retain the prior values.
